// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-address sequencer: FSM state encoding
// and default widths used by the interface and the sequencer itself.
package pc_seq_pkg;

   // State encoding is visible on the State output, so the values are fixed.
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } seq_state_e;

   localparam int DEF_ADDR_W = 7;   // 128-word instruction space
   localparam int DEF_OFFS_W = 10;  // signed branch offset
   localparam int RC_W       = 8;   // redirect counter width
   localparam int FCNT_W     = 2;   // flush counter, holds 1..3

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode/branch logic (master) and the
// fetch-address sequencer (slave).
//
// There is no valid/ready handshake on this bundle: every input is a
// per-cycle qualifier sampled on each rising clock edge, the sequencer
// never back-pressures, and every output is a register that is valid in
// every cycle once reset has been applied.
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OFFS_W = DEF_OFFS_W
);
   logic              Stall;
   logic              BranchTaken;
   logic [ADDR_W-1:0] BranchBase;
   logic [OFFS_W-1:0] BranchOffset;
   logic              Jump;
   logic [ADDR_W-1:0] JumpTarget;
   logic              Halt;
   logic              Resume;
   logic [ADDR_W-1:0] PCin;
   logic              Flush;
   logic              Halted;
   logic [1:0]        State;
   logic [RC_W-1:0]   RedirectCount;

   modport master (
      output Stall, BranchTaken, BranchBase, BranchOffset,
             Jump, JumpTarget, Halt, Resume,
      input  PCin, Flush, Halted, State, RedirectCount
   );

   modport slave (
      input  Stall, BranchTaken, BranchBase, BranchOffset,
             Jump, JumpTarget, Halt, Resume,
      output PCin, Flush, Halted, State, RedirectCount
   );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch target: base + 1 + sign-extended offset, wrapped to
// the address width. Kept separate so the decoder can reuse it for link
// addresses.
module pc_target_calc #(
   parameter int ADDR_W = 7,
   parameter int OFFS_W = 10
) (
   input  logic [ADDR_W-1:0] base_i,
   input  logic [OFFS_W-1:0] offset_i,
   output logic [ADDR_W-1:0] target_o
);
   // Work in whichever width is larger so the sign extension is exact,
   // then keep only the low ADDR_W bits (modulo the address space).
   localparam int SUM_W = (ADDR_W > OFFS_W) ? ADDR_W : OFFS_W;

   logic [SUM_W-1:0] sum_w;

   // Target arithmetic; the offset is relative to the instruction after the branch.
   always_comb begin
      sum_w    = SUM_W'(base_i) + SUM_W'(1) + SUM_W'($signed(offset_i));
      target_o = ADDR_W'(sum_w);
   end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator feeding the instruction memory's PC register.
// Sequential increment, stall hold, jump/branch redirect with a squash
// window covering the memory's read latency, and halt/resume.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int OFFS_W       = DEF_OFFS_W,
   parameter int RESET_PC     = 0,
   parameter int FLUSH_CYCLES = 1   // legal range 1..3
) (
   input  logic           Clock,
   input  logic           Reset,
   pc_sequencer_if.slave  bus
);

   seq_state_e        state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              flush_q;
   logic              halted_q;
   logic [FCNT_W-1:0] fcnt_q;
   logic [RC_W-1:0]   rc_q;

   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] pc_plus1_d;
   logic [RC_W-1:0]   rc_d;

   pc_target_calc #(
      .ADDR_W (ADDR_W),
      .OFFS_W (OFFS_W)
   ) u_target (
      .base_i   (bus.BranchBase),
      .offset_i (bus.BranchOffset),
      .target_o (branch_target)
   );

   // Sequential successor (wraps naturally) and saturating redirect count.
   always_comb begin
      pc_plus1_d = pc_q + ADDR_W'(1);
      rc_d       = (rc_q == {RC_W{1'b1}}) ? rc_q : rc_q + RC_W'(1);
   end

   // Sequencer FSM with the PC, flush counter and redirect counter.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= ST_RUN;
         pc_q     <= ADDR_W'(RESET_PC);
         flush_q  <= 1'b0;
         halted_q <= 1'b0;
         fcnt_q   <= '0;
         rc_q     <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               // Priority: Halt > Jump > BranchTaken > Stall > increment.
               if (bus.Halt) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else if (bus.Jump || bus.BranchTaken) begin
                  pc_q    <= bus.Jump ? bus.JumpTarget : branch_target;
                  flush_q <= 1'b1;
                  fcnt_q  <= FCNT_W'(FLUSH_CYCLES);
                  state_q <= ST_FLUSH;
                  rc_q    <= rc_d;
               end else if (!bus.Stall) begin
                  pc_q <= pc_plus1_d;
               end
            end
            ST_FLUSH: begin
               // Control inputs here come from squashed instructions; only
               // Stall is honoured.
               if (!bus.Stall) begin
                  pc_q   <= pc_plus1_d;
                  fcnt_q <= fcnt_q - FCNT_W'(1);
                  if (fcnt_q == FCNT_W'(1)) begin
                     flush_q <= 1'b0;
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_HALTED: begin
               // Resume overrides a simultaneous Halt.
               if (bus.Resume) begin
                  pc_q     <= pc_plus1_d;
                  halted_q <= 1'b0;
                  state_q  <= ST_RUN;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               flush_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PCin          = pc_q;
   assign bus.Flush         = flush_q;
   assign bus.Halted        = halted_q;
   assign bus.State         = state_q;
   assign bus.RedirectCount = rc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic, all
// predicted by a behavioural model and checked through a scoreboard queue.
module tb_pc_sequencer;
   localparam int ADDR_W = 7;
   localparam int OFFS_W = 10;
   localparam int FLUSH_CYCLES = 1;
   localparam int EXP_W = ADDR_W + 12;
   localparam int ASPACE = 1 << ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) bus ();

   pc_sequencer #(
      .ADDR_W       (ADDR_W),
      .OFFS_W       (OFFS_W),
      .RESET_PC     (0),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   // mode: 0 running, 1 squashing after a redirect, 2 halted
   int m_pc = 0, m_mode = 0, m_left = 0, m_rc = 0;

   function automatic int wrap(input int v);
      return ((v % ASPACE) + ASPACE) % ASPACE;
   endfunction

   task automatic model_redirect(input int target);
      m_pc   = target;
      m_mode = 1;
      m_left = FLUSH_CYCLES;
      m_rc   = (m_rc < 255) ? m_rc + 1 : 255;
   endtask

   task automatic model_step();
      int off;
      if (rst) begin
         m_pc = 0; m_mode = 0; m_left = 0; m_rc = 0;
      end else if (m_mode == 0) begin
         off = int'(bus.BranchOffset);
         if (off >= (1 << (OFFS_W - 1))) off -= (1 << OFFS_W);
         if (bus.Halt) m_mode = 2;
         else if (bus.Jump) model_redirect(int'(bus.JumpTarget));
         else if (bus.BranchTaken) model_redirect(wrap(int'(bus.BranchBase) + 1 + off));
         else if (!bus.Stall) m_pc = wrap(m_pc + 1);
      end else if (m_mode == 1) begin
         if (!bus.Stall) begin
            m_pc = wrap(m_pc + 1);
            m_left--;
            if (m_left == 0) m_mode = 0;
         end
      end else begin
         if (bus.Resume) begin
            m_pc = wrap(m_pc + 1);
            m_mode = 0;
         end
      end
   endtask

   function automatic logic [EXP_W-1:0] model_pack();
      logic [ADDR_W-1:0] p;
      logic [1:0] s;
      logic [7:0] r;
      p = ADDR_W'(m_pc);
      s = 2'(m_mode);
      r = 8'(m_rc);
      return {p, (m_mode == 1), (m_mode == 2), s, r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchBase = '0;
      bus.BranchOffset = '0; bus.Jump = 1'b0; bus.JumpTarget = '0;
      bus.Halt = 1'b0; bus.Resume = 1'b0;
   endtask

   // Inputs are already set by the caller; predict this edge and advance.
   task automatic tick();
      model_step();
      exp_q.push_back(model_pack());
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [EXP_W-1:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.PCin, bus.Flush, bus.Halted, bus.State, bus.RedirectCount};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL sb @%0t: got pc=%0d fl=%0b ha=%0b st=%0d rc=%0d, expected pc=%0d fl=%0b ha=%0b st=%0d rc=%0d",
                        $time, a[EXP_W-1:12], a[11], a[10], a[9:8], a[7:0],
                        e[EXP_W-1:12], e[11], e[10], e[9:8], e[7:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk("reset_pc", int'(bus.PCin), 0);
      chk("reset_state", int'(bus.State), 0);
      chk("reset_rc", int'(bus.RedirectCount), 0);
      rst = 1'b0;

      // 1. free run across the wrap
      for (int k = 1; k <= 129; k++) begin
         tick();
         chk("free_pc", int'(bus.PCin), k % 128);
         chk("free_flush", int'(bus.Flush), 0);
      end

      // 2. stall at 10
      for (int k = 0; k < 9; k++) tick();
      chk("pre_stall_pc", int'(bus.PCin), 10);
      bus.Stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_pc", int'(bus.PCin), 10);
      end
      bus.Stall = 1'b0;
      tick();
      chk("post_stall_pc", int'(bus.PCin), 11);
      chk("stall_rc", int'(bus.RedirectCount), 0);

      // 3. backward branch, then a branch during flush is ignored
      bus.BranchTaken = 1'b1; bus.BranchBase = 7'd20; bus.BranchOffset = 10'h3FB;
      tick();
      chk("br_pc", int'(bus.PCin), 16);
      chk("br_flush", int'(bus.Flush), 1);
      chk("br_state", int'(bus.State), 1);
      bus.BranchBase = 7'd50; bus.BranchOffset = 10'd0;
      tick();
      chk("br_ignored_pc", int'(bus.PCin), 17);
      chk("br_flush_clear", int'(bus.Flush), 0);
      chk("br_rc", int'(bus.RedirectCount), 1);
      idle_inputs();

      // 4. jump beats branch and stall; wrapping branch target
      bus.Jump = 1'b1; bus.JumpTarget = 7'd100;
      bus.BranchTaken = 1'b1; bus.BranchBase = 7'd5; bus.Stall = 1'b1;
      tick();
      chk("jmp_pc", int'(bus.PCin), 100);
      idle_inputs();
      tick();
      chk("jmp_next_pc", int'(bus.PCin), 101);
      bus.BranchTaken = 1'b1; bus.BranchBase = 7'd126; bus.BranchOffset = 10'd3;
      tick();
      chk("br_wrap_pc", int'(bus.PCin), 2);
      chk("br_wrap_rc", int'(bus.RedirectCount), 3);
      idle_inputs();
      tick();

      // 5. halt at 40, jumps ignored, resume
      bus.Jump = 1'b1; bus.JumpTarget = 7'd39;
      tick();
      idle_inputs();
      tick();
      chk("pre_halt_pc", int'(bus.PCin), 40);
      bus.Halt = 1'b1;
      tick();
      chk("halt_flag", int'(bus.Halted), 1);
      chk("halt_state", int'(bus.State), 2);
      bus.Halt = 1'b0; bus.Jump = 1'b1; bus.JumpTarget = 7'd5;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("halted_pc", int'(bus.PCin), 40);
      end
      idle_inputs();
      bus.Resume = 1'b1; bus.Halt = 1'b1;
      tick();
      chk("resume_pc", int'(bus.PCin), 41);
      chk("resume_state", int'(bus.State), 0);
      chk("resume_halted", int'(bus.Halted), 0);
      idle_inputs();

      // 6. reset in the middle of a flush with stall high
      bus.Jump = 1'b1; bus.JumpTarget = 7'd70;
      tick();
      chk("pre_rst_flush", int'(bus.Flush), 1);
      idle_inputs();
      bus.Stall = 1'b1;
      rst = 1'b1;
      tick();
      chk("rst_pc", int'(bus.PCin), 0);
      chk("rst_flush", int'(bus.Flush), 0);
      chk("rst_state", int'(bus.State), 0);
      chk("rst_rc", int'(bus.RedirectCount), 0);
      rst = 1'b0;
      idle_inputs();

      // randomized traffic, long enough to saturate the redirect counter
      for (int k = 0; k < 3000; k++) begin
         bus.Stall        = ($urandom_range(0, 3) == 0);
         bus.BranchTaken  = ($urandom_range(0, 4) == 0);
         bus.BranchBase   = 7'($urandom_range(0, 127));
         bus.BranchOffset = 10'($urandom_range(0, 1023));
         bus.Jump         = ($urandom_range(0, 6) == 0);
         bus.JumpTarget   = 7'($urandom_range(0, 127));
         bus.Halt         = ($urandom_range(0, 24) == 0);
         bus.Resume       = ($urandom_range(0, 3) == 0);
         rst              = ($urandom_range(0, 1499) == 0);
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
      #5;
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
